// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin front end that time-shares one combinational
// 8-bit ALU among NUM_REQ requesters. One operation is in flight at a time:
// IDLE grants and registers the operands onto the ALU, ISSUE samples the ALU
// outputs, and RESP holds the tagged response until it is accepted.

module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    // Requester side
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_opcode,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,

    // Shared response channel
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_result,
    output logic                   rsp_flagC,
    output logic                   rsp_flagZ,

    // ALU side
    output logic [2:0]             alu_opcode,
    output logic [7:0]             alu_op1,
    output logic [7:0]             alu_op2,
    input  logic [15:0]            alu_result,
    input  logic                   alu_flagC,
    input  logic                   alu_flagZ,

    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W-1:0]     w_rr_nxt;
    logic [ID_W-1:0]     w_cand;
    logic                w_any;
    int                  w_idx;
    logic [NUM_REQ-1:0]  w_ready;

    logic [2:0]          w_sel_opcode;
    logic [7:0]          w_sel_a;
    logic [7:0]          w_sel_b;
    logic                w_carry_op;

    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [15:0]         r_rsp_result;
    logic                r_rsp_flagC;
    logic                r_rsp_flagZ;
    logic [2:0]          r_alu_opcode;
    logic [7:0]          r_alu_op1;
    logic [7:0]          r_alu_op2;

    // Rotating-priority search: first valid requester at or above rr_ptr, with wrap.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                w_cand = ID_W'(w_idx);
                if (req_valid[w_cand]) begin
                    w_any   = 1'b1;
                    w_grant = w_cand;
                end
            end
        end
    end

    // Pointer advances to the requester just after the winner, wrapping at NUM_REQ.
    assign w_rr_nxt = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + ID_W'(1);

    // Operand mux for the granted requester.
    assign w_sel_opcode = req_opcode[3*int'(w_grant) +: 3];
    assign w_sel_a      = req_a[8*int'(w_grant) +: 8];
    assign w_sel_b      = req_b[8*int'(w_grant) +: 8];

    // Only add (000) and subtract (001) produce a meaningful carry/borrow.
    assign w_carry_op = (r_alu_opcode[2:1] == 2'b00);

    // Accept strobe: one-hot to the winner while idle, held low during reset.
    always_comb begin
        w_ready = '0;
        if ((r_state == S_IDLE) && w_any && !rst) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // Next-state logic for the grant / issue / response sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)     w_state_nxt = S_ISSUE;
            S_ISSUE:                w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: grant capture, ALU sampling and response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flagC  <= 1'b0;
            r_rsp_flagZ  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_alu_opcode <= w_sel_opcode;
                        r_alu_op1    <= w_sel_a;
                        r_alu_op2    <= w_sel_b;
                        r_rsp_id     <= w_grant;
                        r_rr_ptr     <= w_rr_nxt;
                    end
                end
                S_ISSUE: begin
                    r_rsp_result <= alu_result;
                    r_rsp_flagZ  <= alu_flagZ;
                    r_rsp_flagC  <= w_carry_op ? alu_flagC : 1'b0;
                    r_rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flagC  = r_rsp_flagC;
    assign rsp_flagZ  = r_rsp_flagZ;
    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Round-robin controller that shares one combinational 8-bit ALU (3-bit opcode, two 8-bit operands, 16-bit result, carry and zero flags) among NUM_REQ requesters. It accepts one operation per grant and registers the operands and opcode onto the ALU inputs. It samples the result and flags, then returns them on a shared response channel tagged with the requester ID. The block sits between the requester clients and the single ALU instance in the datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ))

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_opcode  in  3*NUM_REQ  packed opcodes; requester i at [3i+2:3i]
req_a  in  8*NUM_REQ  packed operand 1; requester i at [8i+7:8i]
req_b  in  8*NUM_REQ  packed operand 2
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index owning the response
rsp_result  out  16  captured ALU result
rsp_flagC  out  1  captured carry/borrow
rsp_flagZ  out  1  captured zero flag
alu_opcode  out  3  to ALU Opcode (registered)
alu_op1  out  8  to ALU Operand1 (registered)
alu_op2  out  8  to ALU Operand2 (registered)
alu_result  in  16  from ALU Result
alu_flagC  in  1  from ALU flagC
alu_flagZ  in  1  from ALU flagZ
busy  out  1  high in ISSUE or RESP

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flagC=0, rsp_flagZ=0, alu_opcode=0, alu_op1=0, alu_op2=0, busy=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally in this cycle only; all other req_ready bits are 0.
  - On the edge: capture the granted opcode/a/b into alu_opcode/alu_op1/alu_op2 and the grant index into rsp_id.
  - rr_ptr <= (grant+1) mod NUM_REQ. Go to ISSUE.
  - With no req_valid, remain in IDLE and leave rr_ptr unchanged.
- ISSUE (1 cycle): the ALU inputs are stable. On the edge:
  - rsp_result <= alu_result, rsp_flagZ <= alu_flagZ.
  - rsp_flagC <= alu_flagC if alu_opcode is 000 or 001, else 0. The controller never forwards the ALU's stale carry.
  - rsp_valid <= 1. Go to RESP.
- RESP:
  - Hold rsp_* and alu_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in the RESP cycle, so req_ready=0 throughout ISSUE and RESP.
- Latency: grant cycle G, rsp_valid rises at G+2. Best-case throughput is one operation per 3 cycles.
- req_ready is asserted only while the corresponding req_valid=1. Requesters must hold their inputs stable while valid and not yet accepted.
- Response fields keep their last values after the handshake; only rsp_valid clears.
- rr_ptr changes only on a grant. Simultaneous requests are served in strict rotating order, with no starvation. Worst-case wait is NUM_REQ grants.
- A req_valid that deasserts before it is granted is permitted and is dropped without side effects.
- Opcodes 000..111 are all legal and passed through unchanged.
- Reset mid-operation (ISSUE or RESP): return immediately to reset values. The in-flight operation is discarded with no response.

Test Plan:
- Reset, then req0: opcode 000, a=200, b=100 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x012C, C=1, Z=0.
- req1: opcode 001, a=5, b=5 -> result 0x0000, C=0, Z=1. req1: a=3, b=5 -> result 0xFFFE, C=1, Z=0.
- req2: opcode 010, a=255, b=255 -> result 0xFE01, C=0 (forced), Z=0. Then opcode 101, a=0xFF, b=0xFF -> result 0xFF00, C=0, Z=0.
- All 4 req_valid held high from reset with rsp_ready=1 -> grant order 0,1,2,3,0; rsp_id follows the same order; one response every 3 cycles.
- rsp_ready low for 5 cycles in RESP -> rsp_valid and all rsp_* and alu_* stable; req_ready stays 0; on ready the handshake completes and the next grant follows in the following IDLE cycle.
- Assert rst during ISSUE of req3 -> all outputs at reset values asynchronously; no response for req3; after release with req3 still valid, req3 is granted with rsp_id=3.
